// File: rtl/musa_seq_pkg.sv
// Shared definitions for the MUSA PC sequencer: op encodings, FSM states and fault codes.
package musa_seq_pkg;

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_JR   = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_HALT = 3'd3;
  localparam logic [2:0] OP_JPC  = 3'd4;
  localparam logic [2:0] OP_BRFL = 3'd5;
  localparam logic [2:0] OP_CALL = 3'd6;
  localparam logic [2:0] OP_RET  = 3'd7;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_OVERFLOW  = 2'b01;
  localparam logic [1:0] FC_UNDERFLOW = 2'b10;
  localparam logic [1:0] FC_ILLEGAL   = 2'b11;

endpackage

// File: rtl/musa_ret_stack.sv
// Return-address stack: single-ported register array with occupancy count.
// WRAP=1 lets a push on a full stack overwrite the oldest entry circularly.
module musa_ret_stack #(
  parameter int ADDR_W      = 18,
  parameter int STACK_DEPTH = 8,
  parameter bit WRAP        = 1'b0,
  localparam int PTR_W      = $clog2(STACK_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_top,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_full,
  output logic              o_empty
);

  logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [PTR_W-1:0]  w_top_idx;

  assign o_full    = (r_cnt == CNT_W'(STACK_DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_push_ok = i_push && (!o_full || WRAP);
  assign w_pop_ok  = i_pop && !i_push && !o_empty;
  assign w_top_idx = r_wp - PTR_W'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_cnt     = r_cnt;

  // Contents need no reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= i_data;
  end

  // The write pointer wraps naturally because depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_cnt <= '0;
    end else if (w_push_ok) begin
      r_wp <= r_wp + PTR_W'(1);
      if (!o_full) r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_pop_ok) begin
      r_wp  <= w_top_idx;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/musa_pc_sequencer.sv
// MUSA PC sequencer: PC register, next-PC selection, RUN/HALT/FAULT control and return stack.
// Optional macro MUSA_RAS_WRAP_EN: CALL on a full stack overwrites the oldest return instead of faulting.
module musa_pc_sequencer
  import musa_seq_pkg::*;
#(
  parameter int                ADDR_W      = 18,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   op,
  input  logic                         flag_true,
  input  logic [ADDR_W-1:0]            imm_addr,
  input  logic [ADDR_W-1:0]            reg_addr,
  input  logic                         resume,
  output logic [ADDR_W-1:0]            pc,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         halted,
  output logic                         fault,
  output logic [1:0]                   fault_code
);

`ifdef MUSA_RAS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_halted;
  logic              r_fault;
  logic [1:0]        r_code;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_active;

  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_active = (r_state == ST_RUN) && en;
  assign w_push   = w_active && (op == OP_CALL) && (!w_full || WRAP);
  assign w_pop    = w_active && (op == OP_RET) && !w_empty;

  musa_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .WRAP        (WRAP)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_top),
    .o_cnt   (sp),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_ADDR;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
      r_code   <= FC_NONE;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (en) begin
            case (op)
              OP_SEQ:  r_pc <= w_pc_inc;
              OP_JR:   r_pc <= reg_addr;
              OP_JMP:  r_pc <= imm_addr;
              OP_HALT: begin
                r_state  <= ST_HALT;
                r_halted <= 1'b1;
              end
              OP_JPC:  r_pc <= r_pc + imm_addr;
              OP_BRFL: r_pc <= flag_true ? imm_addr : w_pc_inc;
              OP_CALL: begin
                if (w_full && !WRAP) begin
                  r_state <= ST_FAULT;
                  r_fault <= 1'b1;
                  r_code  <= FC_OVERFLOW;
                end else begin
                  r_pc <= imm_addr;
                end
              end
              OP_RET: begin
                if (w_empty) begin
                  r_state <= ST_FAULT;
                  r_fault <= 1'b1;
                  r_code  <= FC_UNDERFLOW;
                end else begin
                  r_pc <= w_top;
                end
              end
              default: ;
            endcase
          end
        end
        ST_HALT: begin
          if (resume) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
            r_pc     <= w_pc_inc;
          end
        end
        // FAULT is terminal until reset.
        default: ;
      endcase
    end
  end

  assign pc         = r_pc;
  assign halted     = r_halted;
  assign fault      = r_fault;
  assign fault_code = r_code;

endmodule

// File: tb/tb_musa_pc_sequencer.sv
// Self-checking bench for musa_pc_sequencer: directed scenarios plus randomized ops against a queue-based model.
module tb_musa_pc_sequencer;
  localparam int AW = 18;
  localparam int D  = 8;
  localparam int SW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    op = 3'd0;
  logic          flag_true = 1'b0;
  logic [AW-1:0] imm_addr = '0;
  logic [AW-1:0] reg_addr = '0;
  logic          resume = 1'b0;
  logic [AW-1:0] pc;
  logic [SW-1:0] sp;
  logic          halted;
  logic          fault;
  logic [1:0]    fault_code;

  int total = 0;
  int bad   = 0;

  // Model: pc, return addresses (back = top), mode 0 run / 1 halted / 2 faulted.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_q[$];
  int            m_mode;
  logic [1:0]    m_code;
`ifdef MUSA_RAS_WRAP_EN
  localparam bit M_WRAP = 1'b1;
`else
  localparam bit M_WRAP = 1'b0;
`endif

  musa_pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(D), .RESET_ADDR('0)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .flag_true(flag_true),
    .imm_addr(imm_addr), .reg_addr(reg_addr), .resume(resume),
    .pc(pc), .sp(sp), .halted(halted), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = '0; m_q.delete(); m_mode = 0; m_code = 2'b00;
  endtask

  task automatic model_step(input logic e, input logic [2:0] o, input logic f,
                            input logic [AW-1:0] im, input logic [AW-1:0] rg, input logic rs);
    if (m_mode == 1) begin
      if (rs) begin m_pc = m_pc + 1'b1; m_mode = 0; end
    end else if (m_mode == 0 && e) begin
      case (o)
        3'd0: m_pc = m_pc + 1'b1;
        3'd1: m_pc = rg;
        3'd2: m_pc = im;
        3'd3: m_mode = 1;
        3'd4: m_pc = m_pc + im;
        3'd5: m_pc = f ? im : m_pc + 1'b1;
        3'd6: begin
          if (m_q.size() < D || M_WRAP) begin
            if (m_q.size() == D) void'(m_q.pop_front());
            m_q.push_back(m_pc + 1'b1);
            m_pc = im;
          end else begin
            m_mode = 2; m_code = 2'b01;
          end
        end
        default: begin
          if (m_q.size() == 0) begin m_mode = 2; m_code = 2'b10; end
          else m_pc = m_q.pop_back();
        end
      endcase
    end
  endtask

  // Drive one cycle on the falling edge, advance the model, sample 1 ns after the rising edge.
  task automatic apply(input logic e, input logic [2:0] o, input logic f,
                       input logic [AW-1:0] im, input logic [AW-1:0] rg, input logic rs);
    @(negedge clk);
    en = e; op = o; flag_true = f; imm_addr = im; reg_addr = rg; resume = rs;
    model_step(e, o, f, im, rg, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; resume = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pc !== 18'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", pc); end
    total++; if (sp !== '0) begin bad++; $display("FAIL reset_sp got=%0d want=0", sp); end
    total++; if ({halted, fault, fault_code} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {halted, fault, fault_code}); end
  endtask

  task automatic test_seq_en();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      apply(1'b1, 3'd0, 1'b0, '0, '0, 1'b0);
      total++; if (pc !== AW'(i)) begin bad++; $display("FAIL seq_pc got=%h want=%h", pc, AW'(i)); end
    end
    apply(1'b0, 3'd2, 1'b0, 18'h155, '0, 1'b1);
    total++; if (pc !== 18'h3) begin bad++; $display("FAIL en_low_hold got=%h want=3", pc); end
  endtask

  task automatic test_branch();
    apply(1'b1, 3'd5, 1'b0, 18'h100, '0, 1'b0);
    total++; if (pc !== 18'h4) begin bad++; $display("FAIL brfl_false got=%h want=4", pc); end
    apply(1'b1, 3'd5, 1'b1, 18'h100, '0, 1'b0);
    total++; if (pc !== 18'h100) begin bad++; $display("FAIL brfl_true got=%h want=100", pc); end
    apply(1'b1, 3'd1, 1'b0, 18'h777, 18'h3FFFF, 1'b0);
    total++; if (pc !== 18'h3FFFF) begin bad++; $display("FAIL jr got=%h want=3ffff", pc); end
    apply(1'b1, 3'd4, 1'b0, 18'h2, '0, 1'b0);
    total++; if (pc !== 18'h1) begin bad++; $display("FAIL jpc_wrap got=%h want=1", pc); end
    apply(1'b1, 3'd2, 1'b0, 18'h3FFFF, '0, 1'b0);
    apply(1'b1, 3'd0, 1'b0, '0, '0, 1'b0);
    total++; if (pc !== 18'h0) begin bad++; $display("FAIL seq_wrap got=%h want=0", pc); end
  endtask

  task automatic test_call_ret();
    do_reset();
    apply(1'b1, 3'd2, 1'b0, 18'h10, '0, 1'b0);
    apply(1'b1, 3'd6, 1'b0, 18'h40, '0, 1'b0);
    total++; if (pc !== 18'h40 || sp !== SW'(1)) begin bad++; $display("FAIL call1 pc=%h sp=%0d want 40/1", pc, sp); end
    apply(1'b1, 3'd6, 1'b0, 18'h80, '0, 1'b0);
    total++; if (pc !== 18'h80 || sp !== SW'(2)) begin bad++; $display("FAIL call2 pc=%h sp=%0d want 80/2", pc, sp); end
    apply(1'b1, 3'd7, 1'b0, '0, '0, 1'b0);
    total++; if (pc !== 18'h41 || sp !== SW'(1)) begin bad++; $display("FAIL ret1 pc=%h sp=%0d want 41/1", pc, sp); end
    apply(1'b1, 3'd7, 1'b0, '0, '0, 1'b0);
    total++; if (pc !== 18'h11 || sp !== SW'(0)) begin bad++; $display("FAIL ret2 pc=%h sp=%0d want 11/0", pc, sp); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      apply(1'b1, 3'd6, 1'b0, AW'(i * 18'h1000), '0, 1'b0);
      total++; if (pc !== m_pc || sp !== SW'(m_q.size()) || fault !== (m_mode == 2)) begin
        bad++; $display("FAIL call_deep%0d pc=%h sp=%0d fault=%b want %h/%0d", i, pc, sp, fault, m_pc, m_q.size()); end
    end
    total++; if (fault_code !== (M_WRAP ? 2'b00 : 2'b01) || pc !== (M_WRAP ? 18'h9000 : 18'h8000)) begin
      bad++; $display("FAIL overflow_9th code=%b pc=%h", fault_code, pc); end
    for (int i = 1; i <= 9; i++) begin
      apply(1'b1, 3'd7, 1'b0, '0, '0, 1'b0);
      total++; if (pc !== m_pc || sp !== SW'(m_q.size()) || fault_code !== m_code) begin
        bad++; $display("FAIL ret_deep%0d pc=%h sp=%0d code=%b want %h/%0d/%b", i, pc, sp, fault_code, m_pc, m_q.size(), m_code); end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    apply(1'b1, 3'd2, 1'b0, 18'h55, '0, 1'b0);
    apply(1'b1, 3'd7, 1'b0, '0, '0, 1'b0);
    total++; if (fault !== 1'b1 || fault_code !== 2'b10 || pc !== 18'h55) begin
      bad++; $display("FAIL underflow fault=%b code=%b pc=%h want 1/10/55", fault, fault_code, pc); end
    apply(1'b1, 3'd0, 1'b0, '0, '0, 1'b1);
    apply(1'b1, 3'd2, 1'b0, 18'h99, '0, 1'b0);
    total++; if (pc !== 18'h55 || fault !== 1'b1) begin bad++; $display("FAIL fault_hold pc=%h want 55", pc); end
    do_reset();
    total++; if (pc !== 18'h0 || fault !== 1'b0 || fault_code !== 2'b00) begin
      bad++; $display("FAIL fault_clear pc=%h fault=%b code=%b", pc, fault, fault_code); end
  endtask

  task automatic test_halt();
    do_reset();
    apply(1'b1, 3'd2, 1'b0, 18'h20, '0, 1'b0);
    apply(1'b1, 3'd3, 1'b0, '0, '0, 1'b0);
    total++; if (halted !== 1'b1 || pc !== 18'h20) begin bad++; $display("FAIL halt_enter halted=%b pc=%h", halted, pc); end
    repeat (5) apply(1'b1, 3'd0, 1'b0, '0, '0, 1'b0);
    total++; if (pc !== 18'h20 || halted !== 1'b1) begin bad++; $display("FAIL halt_hold pc=%h want 20", pc); end
    apply(1'b1, 3'd0, 1'b0, '0, '0, 1'b1);
    total++; if (pc !== 18'h21 || halted !== 1'b0) begin bad++; $display("FAIL resume pc=%h halted=%b want 21/0", pc, halted); end
    apply(1'b0, 3'd0, 1'b0, '0, '0, 1'b1);
    total++; if (pc !== 18'h21) begin bad++; $display("FAIL resume_in_run pc=%h want 21", pc); end
  endtask

  task automatic test_async_reset();
    apply(1'b1, 3'd2, 1'b0, 18'h1234, '0, 1'b0);
    apply(1'b1, 3'd6, 1'b0, 18'h2000, '0, 1'b0);
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (pc !== 18'h0 || sp !== '0 || clk !== 1'b0) begin
      bad++; $display("FAIL async_reset pc=%h sp=%0d want 0/0 before edge", pc, sp); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [2:0] o;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      o = 3'($urandom_range(0, 7));
      if (o == 3'd3 && $urandom_range(0, 2) != 0) o = 3'd6;
      apply($urandom_range(0, 9) != 0, o, 1'($urandom), AW'($urandom), AW'($urandom),
            $urandom_range(0, 4) == 0);
      total++;
      if (pc !== m_pc || sp !== SW'(m_q.size()) || halted !== (m_mode == 1) ||
          fault !== (m_mode == 2) || fault_code !== m_code) begin
        bad++;
        $display("FAIL random%0d pc=%h sp=%0d h=%b f=%b c=%b want %h/%0d/%0d/%b",
                 n, pc, sp, halted, fault, fault_code, m_pc, m_q.size(), m_mode, m_code);
      end
      if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    #12;
    test_reset();
    test_seq_en();
    test_branch();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_halt();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
